// File: rtl/osl_tx_fifo_pkg.sv
// Shared definitions for the OSL transmit path.
//   OSL_WORDSZ   - link data word width, common to osl_rxtx and both FIFOs
//   OSL_CLKPHASE - clock phase selection shared with osl_rxtx
//   osl_txf_*    - encodings of the transmit-FIFO link state machine
package osl_tx_fifo_pkg;

  localparam int OSL_WORDSZ   = 32;
  localparam int OSL_CLKPHASE = 0;

  typedef enum logic [1:0] {
    osl_txf_idle  = 2'd0,
    osl_txf_pulse = 2'd1,
    osl_txf_hold  = 2'd2
  } osl_txf_state_e;

endpackage

// File: rtl/osl_tx_fifo_fifo.sv
// osl_fifo: circular-buffer FIFO shared by the OSL TX and RX sides.
// Ports:
//   clk, resetb        - clock, synchronous active-low reset
//   wr_i, wdata_i      - push strobe and data (ignored while full)
//   rd_i, rdata_o      - pop strobe (ignored while empty), head word (show-ahead)
//   full_o, empty_o    - registered status flags
//   level_o            - registered occupancy, 0..DEPTH
// DEPTH must be a power of two in 2..256.
module osl_fifo #(
  parameter int WORDSZ = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     wr_i,
  input  logic [WORDSZ-1:0]        wdata_i,
  input  logic                     rd_i,
  output logic [WORDSZ-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WORDSZ-1:0] mem_q [DEPTH];

  // Pointers carry one wrap bit above the index so full and empty are
  // distinguishable when the indices coincide.
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [AW:0] level_q, level_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        do_wr, do_rd;

  // Acceptance looks only at the registered flags, so a push into a full
  // FIFO is rejected even when a pop frees a slot on the same edge.
  assign do_wr = wr_i & ~full_q;
  assign do_rd = rd_i & ~empty_q;

  always_comb begin
    wptr_d  = do_wr ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_rd ? rptr_q + 1'b1 : rptr_q;
    // Modular difference of the extended pointers is the occupancy directly.
    level_d = wptr_d - rptr_d;
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[AW-1:0] == rptr_d[AW-1:0]) && (wptr_d[AW] != rptr_d[AW]);
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/osl_tx_fifo.sv
// osl_tx_fifo: buffers producer words and hands them to osl_rxtx one at a
// time.
// Ports:
//   clk, resetb                  - clock, synchronous active-low reset
//   in_wr, in_din                - producer write strobe and data
//   in_full, in_empty, in_level  - registered FIFO status
//   in_ovf                       - sticky: a write was attempted while full
//   link_dir                     - osl_rxtx host_dir (transmitter ready)
//   link_wr, link_din            - osl_rxtx host_wr pulse and registered data
//   dbg_state_o                  - current link state, for observation
//
// Link handshake: a word is popped and offered only when the FSM is IDLE,
// the FIFO is non-empty and link_dir=1 on that edge; link_wr is then high for
// exactly one cycle with link_din already valid. The FSM then sits in HOLD
// until the transmitter drops link_dir (it has taken the word) or HOLD_MAX+1
// cycles pass, and only then looks for a fresh link_dir=1. link_din holds its
// value until the next pop.
module osl_tx_fifo
  import osl_tx_fifo_pkg::*;
#(
  parameter int WORDSZ   = OSL_WORDSZ,
  parameter int DEPTH    = 8,
  parameter int HOLD_MAX = 15
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     in_wr,
  input  logic [WORDSZ-1:0]        in_din,
  output logic                     in_full,
  output logic                     in_empty,
  output logic [$clog2(DEPTH):0]   in_level,
  output logic                     in_ovf,
  input  logic                     link_dir,
  output logic                     link_wr,
  output logic [WORDSZ-1:0]        link_din,
  output osl_txf_state_e           dbg_state_o
);

  localparam int HCW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_MAX);

  osl_txf_state_e    state_q, state_d;
  logic [HCW-1:0]    hold_cnt_q, hold_cnt_d;
  logic              link_wr_q, link_wr_d;
  logic [WORDSZ-1:0] link_din_q, link_din_d;
  logic              ovf_q, ovf_d;
  logic              pop;
  logic [WORDSZ-1:0] head;
  logic              fifo_full, fifo_empty;

  osl_fifo #(
    .WORDSZ (WORDSZ),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetb  (resetb),
    .wr_i    (in_wr),
    .wdata_i (in_din),
    .rd_i    (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (in_level)
  );

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    pop        = 1'b0;
    unique case (state_q)
      osl_txf_idle: begin
        if (!fifo_empty && link_dir) begin
          pop     = 1'b1;
          state_d = osl_txf_pulse;
        end
      end
      osl_txf_pulse: begin
        state_d    = osl_txf_hold;
        hold_cnt_d = '0;
      end
      osl_txf_hold: begin
        if (!link_dir || hold_cnt_q == HOLD_LAST) begin
          state_d = osl_txf_idle;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = osl_txf_idle;
    endcase

    link_wr_d  = pop;
    link_din_d = pop ? head : link_din_q;
    ovf_d      = ovf_q | (in_wr & fifo_full);
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q    <= osl_txf_idle;
      hold_cnt_q <= '0;
      link_wr_q  <= 1'b0;
      link_din_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      link_wr_q  <= link_wr_d;
      link_din_q <= link_din_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_full     = fifo_full;
  assign in_empty    = fifo_empty;
  assign in_ovf      = ovf_q;
  assign link_wr     = link_wr_q;
  assign link_din    = link_din_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/osl_tx_fifo.md
OSL_TX_FIFO -- requirements
Module: osl_tx_fifo

Interface
REQ-001 Parameter WORDSZ, default `WORDSZ from osl.h (32): data word width, SHALL match osl_rxtx.
REQ-002 Parameter DEPTH, default 8: FIFO entries; SHALL be a power of two, 2..256.
REQ-003 Parameter HOLD_MAX, default 15: maximum HOLD cycles waiting for link_dir to fall.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 resetb  input  1  reset, synchronous, active-low.
REQ-006 in_wr  input  1  producer write strobe; one word per high cycle.
REQ-007 in_din  input  WORDSZ  producer data, sampled when in_wr=1.
REQ-008 in_full  output  1  FIFO full; writes are rejected.
REQ-009 in_empty  output  1  FIFO empty.
REQ-010 in_level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 in_ovf  output  1  sticky flag: a write was attempted while full.
REQ-012 link_dir  input  1  osl_rxtx host_dir: transmitter ready.
REQ-013 link_wr  output  1  osl_rxtx host_wr: one-cycle write pulse.
REQ-014 link_din  output  WORDSZ  osl_rxtx host_din: registered data to transmit.

Function
REQ-015 Storage SHALL be a circular buffer with read/write pointers carrying one extra wrap bit; full = indices equal and wrap bits differ, empty = pointers equal.
REQ-016 A write SHALL be accepted iff in_wr=1 and in_full=0 at the sampling edge, including when a pop occurs in the same cycle.
REQ-017 A write while full SHALL be dropped, leave the contents and pointers unchanged, and set in_ovf; in_ovf SHALL clear only on reset.
REQ-018 in_full, in_empty and in_level SHALL be registered and reflect the state after each edge; a simultaneous push and pop SHALL leave in_level unchanged.
REQ-019 Link FSM states: IDLE, PULSE, HOLD.
REQ-020 IDLE -> PULSE when in_empty=0 and link_dir=1: pop the head word into link_din and drive link_wr=1 for exactly one cycle.
REQ-021 PULSE -> HOLD unconditionally; link_wr SHALL be 0 in HOLD.
REQ-022 HOLD -> IDLE when link_dir=0 or the hold counter reaches HOLD_MAX; the counter SHALL clear on entry to HOLD.
REQ-023 link_din SHALL remain stable from PULSE until the next pop.
REQ-024 Latency: for a word accepted at edge N into an empty FIFO, with the FSM in IDLE and link_dir=1, link_wr SHALL be high during the cycle after edge N+1.
REQ-025 Back-to-back words SHALL each require a fresh link_dir=1 observed in IDLE; no pulse SHALL be issued while link_dir=0.
REQ-026 Words SHALL leave in strict FIFO order, with no loss except drops under REQ-017.
REQ-027 Pointer wrap at DEPTH SHALL be seamless, with no bubble cycle.

Reset
REQ-028 While resetb=0 at an edge: pointers=0, state=IDLE, hold counter=0, link_wr=0, link_din=0, in_full=0, in_empty=1, in_level=0, in_ovf=0.
REQ-029 Reset mid-transfer (PULSE or HOLD) SHALL discard all buffered words and the in-flight word, with no further link_wr pulse.
REQ-030 Storage array contents need not be reset.

Structure
REQ-031 WORDSZ and CLKPHASE SHALL come from shared header osl.h; the FSM state encodings SHALL be defined there as osl_txf_* constants.
REQ-032 Storage plus pointers SHALL be a sub-module osl_fifo (parameters WORDSZ, DEPTH) so the RX side can reuse it; the FSM and counter reside in osl_tx_fifo.

Verification
REQ-033 After reset, write 0x01234567 with link_dir=1 held -> link_wr high for one cycle two edges later, link_din=0x01234567, in_empty=1 afterwards.
REQ-034 Fill 8 words 0x0..0x7 with link_dir=0 -> in_full=1, in_level=8; 9th write 0xDEADBEEF -> in_ovf=1, level stays 8; raise link_dir -> 0x0..0x7 emitted in order, 0xDEADBEEF never emitted.
REQ-035 Full FIFO, simultaneous in_wr and pop -> write rejected, level goes 8->7, in_ovf=1.
REQ-036 Hold link_dir=1 permanently with 3 words queued -> each HOLD exits after HOLD_MAX+1 cycles, all 3 words pulsed.
REQ-037 Connect to osl_rxtx pair, stream 20 words including wrap -> receiver sees 0x89ABCDEF etc. in order, no mismatch.
REQ-038 Assert resetb=0 during HOLD with 4 words queued -> next cycle in_level=0, in_empty=1, no link_wr for 20 cycles after release.
